// File: rtl/uart_loopback_frame_link_if.sv
// Interface for the loopback frame link: start and word inputs, recovered word and done strobe.
// The bench drives through master; the link itself sits on slave.
interface uart_loopback_frame_link_if;
    logic        manual_start;
    logic [63:0] data_in_64;
    logic [63:0] data_out_64;
    logic        data_out_done;

    modport master (
        output manual_start,
        output data_in_64,
        input  data_out_64,
        input  data_out_done
    );

    modport slave (
        input  manual_start,
        input  data_in_64,
        output data_out_64,
        output data_out_done
    );
endinterface

// File: rtl/uart_loopback_frame_link.sv
// 64-bit word sent as eight 8N1 bytes, MSB byte first, over an internal loopback line.
// A UART receiver on the same line reassembles the word and strobes done once per frame.
module uart_loopback_frame_link #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int BAUD_DIV  = CLK_FREQ / BAUD,
    parameter int GAP_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_loopback_frame_link_if.slave     bus
);
    localparam logic [31:0] BIT_LAST  = 32'(BAUD_DIV - 1);
    localparam logic [31:0] HALF_LAST = 32'(BAUD_DIV / 2 - 1);
    // GAP lasts GAP_BYTES*10 bit times minus the one LATCH cycle.
    localparam logic [31:0] GAP_LAST  = 32'(GAP_BYTES * 10 * BAUD_DIV - 2);

    typedef enum logic [1:0] {TX_IDLE, TX_LATCH, TX_SEND, TX_GAP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t   tx_state, tx_state_nxt;
    logic [31:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [2:0]  tx_byte;
    logic [63:0] tx_shreg;
    logic [7:0]  tx_byte_cur;
    logic        tx_line;

    rx_state_t   rx_state, rx_state_nxt;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_byte;
    logic [2:0]  rx_nbytes;
    logic [55:0] rx_word;
    logic [63:0] data_out_q;
    logic        done_q;

    assign bus.data_out_64   = data_out_q;
    assign bus.data_out_done = done_q;
    assign rx_s              = rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst_n) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (bus.manual_start) tx_state_nxt = TX_LATCH;
            TX_LATCH: tx_state_nxt = TX_SEND;
            TX_SEND:  if (tx_cnt == BIT_LAST && tx_bit == 4'd9 && tx_byte == 3'd7)
                          tx_state_nxt = TX_GAP;
            TX_GAP:   if (tx_cnt == GAP_LAST) tx_state_nxt = TX_LATCH;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_shreg <= '0;
        end else begin
            case (tx_state)
                TX_LATCH: begin
                    tx_shreg <= bus.data_in_64;
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx_byte  <= '0;
                end
                TX_SEND: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_bit   <= '0;
                            tx_byte  <= tx_byte + 3'd1;
                            tx_shreg <= tx_shreg << 8;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 32'd1;
                    end
                end
                TX_GAP:  tx_cnt <= tx_cnt + 32'd1;
                default: tx_cnt <= '0;
            endcase
        end
    end

    // Bit slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_comb begin
        tx_line     = 1'b1;
        tx_byte_cur = tx_shreg[63:56];
        if (tx_state == TX_SEND) begin
            if (tx_bit == 4'd0)      tx_line = 1'b0;
            else if (tx_bit != 4'd9) tx_line = tx_byte_cur[3'(tx_bit - 4'd1)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_sync  <= {rx_sync[0], tx_line};
            rx_prev  <= rx_s;
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s && rx_prev) rx_state_nxt = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_cnt == BIT_LAST) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_nbytes  <= '0;
            rx_word    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (rx_state)
                RX_START: rx_cnt <= (rx_cnt == HALF_LAST) ? 32'd0 : rx_cnt + 32'd1;
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s, rx_byte[7:1]};
                        rx_bit  <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 32'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        // A low stop bit drops the byte and restarts word assembly.
                        if (!rx_s) begin
                            rx_nbytes <= '0;
                        end else if (rx_nbytes == 3'd7) begin
                            data_out_q <= {rx_word, rx_byte};
                            done_q     <= 1'b1;
                            rx_nbytes  <= '0;
                        end else begin
                            rx_word   <= {rx_word[47:0], rx_byte};
                            rx_nbytes <= rx_nbytes + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 32'd1;
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loopback_frame_link.sv
// Scoreboard bench for the loopback link, run at 10 clocks per bit so a frame is 1000 cycles.
module tb_uart_loopback_frame_link;
    localparam int BD        = 10;
    localparam int FRAME     = 100 * BD;
    localparam int LAT_MIN   = 7 * 10 * BD + 9 * BD + BD / 2;
    localparam int LAT_MAX   = LAT_MIN + 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   latch_cyc = 0;
    int   last_done_cyc = -1;
    logic [63:0] prev_val = '0;
    logic        prev_done = 1'b0;
    logic [63:0] exp_q[$];

    uart_loopback_frame_link_if bus ();

    uart_loopback_frame_link #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .GAP_BYTES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every done strobe and checks latency, period, width, stability.
    always @(negedge clk) begin
        if (rst_n) begin
            last_done_cyc = -1;
            prev_val      = '0;
            prev_done     = 1'b0;
        end else begin
            if (bus.data_out_done) begin
                if (prev_done) begin
                    miscompares++;
                    $display("FAIL done_width: done high on consecutive cycles at %0d", cyc);
                end
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got word %h expected no pulse", bus.data_out_64);
                end else begin
                    chk("word", bus.data_out_64, exp_q.pop_front());
                    vectors++;
                    if (last_done_cyc < 0) begin
                        if (cyc - latch_cyc < LAT_MIN || cyc - latch_cyc > LAT_MAX) begin
                            miscompares++;
                            $display("FAIL latency: got %0d expected %0d..%0d",
                                     cyc - latch_cyc, LAT_MIN, LAT_MAX);
                        end
                    end else if (cyc - last_done_cyc != FRAME) begin
                        miscompares++;
                        $display("FAIL period: got %0d expected %0d", cyc - last_done_cyc, FRAME);
                    end
                end
                last_done_cyc = cyc;
            end else if (bus.data_out_64 !== prev_val) begin
                miscompares++;
                $display("FAIL stable: got %h expected %h", bus.data_out_64, prev_val);
            end
            prev_val  = bus.data_out_64;
            prev_done = bus.data_out_done;
        end
    end

    logic [9:0] probe_bits;

    initial begin
        rst_n            = 1'b1;
        bus.manual_start = 1'b0;
        bus.data_in_64   = '0;
        step(5);
        chk("rst_out", bus.data_out_64, 64'h0);
        chk("rst_done", {63'h0, bus.data_out_done}, 64'h0);
        chk("rst_line", {63'h0, dut.tx_line}, 64'h1);

        bus.manual_start = 1'b1;
        step(3);
        chk("rst_hold_line", {63'h0, dut.tx_line}, 64'h1);
        chk("rst_hold_done", {63'h0, bus.data_out_done}, 64'h0);

        // Start held across reset release: LATCH follows the first non-reset edge.
        bus.data_in_64 = 64'h2d7e66091ed0a403;
        exp_q.push_back(64'h2d7e66091ed0a403);
        rst_n = 1'b0;
        step(1);
        latch_cyc = cyc;
        chk("latch_line", {63'h0, dut.tx_line}, 64'h1);
        step(1);
        chk("start_bit", {63'h0, dut.tx_line}, 64'h0);
        bus.manual_start = 1'b0;

        step(98);
        bus.data_in_64 = 64'hd253328dd2c0fc3c;
        exp_q.push_back(64'hd253328dd2c0fc3c);
        step(1000);
        bus.data_in_64 = 64'h8162476652bdd1d0;
        exp_q.push_back(64'h8162476652bdd1d0);

        // Interrupt frame 4 in the middle of byte 4.
        step(2350);
        chk("q_empty_before_reset", 64'(exp_q.size()), 64'h0);
        rst_n = 1'b1;
        step(1);
        chk("midrst_out", bus.data_out_64, 64'h0);
        chk("midrst_done", {63'h0, bus.data_out_done}, 64'h0);
        chk("midrst_line", {63'h0, dut.tx_line}, 64'h1);
        step(2);
        rst_n = 1'b0;
        step(20);
        chk("idle_line", {63'h0, dut.tx_line}, 64'h1);
        chk("idle_out", bus.data_out_64, 64'h0);

        bus.data_in_64 = 64'h0123456789abcdef;
        exp_q.push_back(64'h0123456789abcdef);
        bus.manual_start = 1'b1;
        step(1);
        latch_cyc = cyc;
        bus.manual_start = 1'b0;
        // Byte 0x01 on the line: start, 1,0,0,0,0,0,0,0, stop.
        probe_bits = 10'b1_00000001_0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("bit%0d_first", i), {63'h0, dut.tx_line}, {63'h0, probe_bits[i]});
            step(BD - 1);
            chk($sformatf("bit%0d_last", i), {63'h0, dut.tx_line}, {63'h0, probe_bits[i]});
        end

        for (int t = 0; t < 1500 && exp_q.size() != 0; t++) step(1);
        chk("final_q_empty", 64'(exp_q.size()), 64'h0);
        step(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
